dac_top_level_schematic: RTL and testbench

// - Behavioural top level of a segmented differential DAC: 17-bit thermometer MSB segment plus 7-bit binary LSB segment.
// - Registers the complementary data buses on clkin and drives real-valued differential outputs Vout/Voutb.
// - Also provides a calibration-current pass-through (Ical) and a 10-line analog test bus (atb).
// - Sits between the digital datapath (stimulus/encoder) and the analog output stage.

---
 rtl/dac_pkg.sv | 30 +++
 rtl/dac_therm_decoder.sv | 27 ++
 rtl/dac_top_level_schematic.sv | 85 ++++++++
 tb/tb_dac_top_level_schematic.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants for the segmented differential DAC.
// Thermometer MSBs plus binary LSBs, code range 0..2303.
package dac_pkg;

  localparam int N_BIN      = 7;
  localparam int N_THERM    = 17;
  localparam int N_ATB      = 10;
  localparam int CODE_MAX   = 2303;
  localparam int LSB_WEIGHT = 128;
  localparam int CNT_W      = 5;
  localparam int CODE_W     = 12;

  localparam int ATB_VOUT  = 0;
  localparam int ATB_VOUTB = 1;
  localparam int ATB_V1P8  = 2;
  localparam int ATB_V0P8  = 3;
  localparam int ATB_VSS   = 4;
  localparam int ATB_ICAL  = 5;
  localparam int ATB_DICAL = 6;
  localparam int ATB_CODE  = 7;
  localparam int ATB_VCM   = 8;
  localparam int ATB_PDB   = 9;

  function automatic real code_frac(
    input logic [CODE_W-1:0] c
  );
    return real'(c) / real'(CODE_MAX);
  endfunction

endpackage

// File: rtl/dac_therm_decoder.sv
// Thermometer popcount and code assembly.
// Flags whether both complementary buses agree.
import dac_pkg::*;

module dac_therm_decoder (
  input  logic [0:N_THERM-1] therm,
  input  logic [0:N_THERM-1] thermb,
  input  logic [0:N_BIN-1]   bin,
  input  logic [0:N_BIN-1]   binb,
  output logic [CODE_W-1:0]  code,
  output logic               valid
);

  logic [CNT_W-1:0] cnt;

  // count ones; thermometer ordering does not matter
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_THERM; i++) begin
      cnt = cnt + CNT_W'(therm[i]);
    end
    code = CODE_W'(cnt) * CODE_W'(LSB_WEIGHT)
         + CODE_W'(bin);
    valid = (bin == ~binb) && (therm == ~thermb);
  end

endmodule

// File: rtl/dac_top_level_schematic.sv
// Behavioural top of the segmented differential DAC.
// Registers the code, drives real outputs and test bus.
import dac_pkg::*;

module dac_top_level_schematic (
  input  logic               clkin,
  input  logic               rst,
  input  logic               clkinb,
  input  logic               pdb,
  input  logic [0:N_BIN-1]   datainbin,
  input  logic [0:N_BIN-1]   datainbinb,
  input  logic [0:N_THERM-1] dataintherm,
  input  logic [0:N_THERM-1] datainthermb,
  input  logic [0:N_ATB-1]   atb_ena,
  input  real                dataical,
  input  real                vddana_1p8,
  input  real                vddana_0p8,
  input  real                vssana,
  output real                Vout,
  output real                Voutb,
  output real                Ical,
  output real                atb [0:N_ATB-1]
);

  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] code_q;
  logic              valid;
  logic              unused_clkinb;
  real               vfs;
  real               src [0:N_ATB-1];

  assign unused_clkinb = clkinb;

  dac_therm_decoder u_dec (
    .therm  (dataintherm),
    .thermb (datainthermb),
    .bin    (datainbin),
    .binb   (datainbinb),
    .code   (code),
    .valid  (valid)
  );

  // code register; bad complements hold last code
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      code_q <= '0;
    end else if (!pdb) begin
      code_q <= '0;
    end else if (valid) begin
      code_q <= code;
    end
  end

  // differential outputs; power-down forces ground
  always_comb begin
    vfs   = vddana_0p8 - vssana;
    Vout  = vssana;
    Voutb = vssana;
    Ical  = 0.0;
    if (pdb) begin
      Vout  = vssana + vfs * code_frac(code_q);
      Voutb = vssana + vfs
            * code_frac(CODE_W'(CODE_MAX) - code_q);
      Ical  = dataical;
    end
  end

  // analog test bus source select and gating
  always_comb begin
    src[ATB_VOUT]  = Vout;
    src[ATB_VOUTB] = Voutb;
    src[ATB_V1P8]  = vddana_1p8;
    src[ATB_V0P8]  = vddana_0p8;
    src[ATB_VSS]   = vssana;
    src[ATB_ICAL]  = Ical;
    src[ATB_DICAL] = dataical;
    src[ATB_CODE]  = code_frac(code_q);
    src[ATB_VCM]   = (Vout + Voutb) / 2.0;
    src[ATB_PDB]   = pdb ? vddana_1p8 : 0.0;
    for (int i = 0; i < N_ATB; i++) begin
      atb[i] = atb_ena[i] ? src[i] : 0.0;
    end
  end

endmodule

// File: tb/tb_dac_top_level_schematic.sv
// Directed and random checks of the DAC top.
// Reference model tracks the code as a plain integer.
module tb_dac_top_level_schematic;

  logic        clkin = 1'b0;
  logic        clkinb;
  logic        rst;
  logic        pdb;
  logic [0:6]  datainbin;
  logic [0:6]  datainbinb;
  logic [0:16] dataintherm;
  logic [0:16] datainthermb;
  logic [0:9]  atb_ena;
  real         dataical;
  real         vddana_1p8;
  real         vddana_0p8;
  real         vssana;
  real         Vout;
  real         Voutb;
  real         Ical;
  real         atb [0:9];

  int vectors = 0;
  int miscompares = 0;
  int exp_code = 0;
  bit stim_valid = 1'b1;

  always #5 clkin = ~clkin;
  assign clkinb = ~clkin;

  dac_top_level_schematic dut (
    .clkin        (clkin),
    .rst          (rst),
    .clkinb       (clkinb),
    .pdb          (pdb),
    .datainbin    (datainbin),
    .datainbinb   (datainbinb),
    .dataintherm  (dataintherm),
    .datainthermb (datainthermb),
    .atb_ena      (atb_ena),
    .dataical     (dataical),
    .vddana_1p8   (vddana_1p8),
    .vddana_0p8   (vddana_0p8),
    .vssana       (vssana),
    .Vout         (Vout),
    .Voutb        (Voutb),
    .Ical         (Ical),
    .atb          (atb)
  );

  function automatic int ones(input logic [0:16] t);
    int n = 0;
    for (int i = 0; i < 17; i++) n += int'(t[i]);
    return n;
  endfunction

  task automatic chk(input string tag,
                     input real obs,
                     input real exp);
    bit ok;
    ok = ((obs - exp) < 1e-12) && ((exp - obs) < 1e-12);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s observed=%g expected=%g",
             tag, obs, exp);
    end
  endtask

  // bad < 0: clean; 0..6 flip binb bit; 7..23 flip thermb
  task automatic drive(input logic [0:16] t,
                       input logic [0:6] b,
                       input int bad);
    dataintherm  = t;
    datainbin    = b;
    datainthermb = ~t;
    datainbinb   = ~b;
    if (bad >= 0 && bad < 7)
      datainbinb[bad] = ~datainbinb[bad];
    else if (bad >= 7)
      datainthermb[bad-7] = ~datainthermb[bad-7];
    stim_valid = (bad < 0);
  endtask

  task automatic edge_step();
    @(posedge clkin);
    if (rst || !pdb)
      exp_code = 0;
    else if (stim_valid)
      exp_code = ones(dataintherm) * 128
               + int'(datainbin);
    #1;
  endtask

  task automatic check_all(input string tag);
    real frac, vfs, ev, evb, ei;
    real src [0:9];
    frac = real'(exp_code) / 2303.0;
    vfs  = vddana_0p8 - vssana;
    ev   = pdb ? vssana + vfs * frac : vssana;
    evb  = pdb ? vssana + vfs * (1.0 - frac) : vssana;
    ei   = pdb ? dataical : 0.0;
    src[0] = ev;
    src[1] = evb;
    src[2] = vddana_1p8;
    src[3] = vddana_0p8;
    src[4] = vssana;
    src[5] = ei;
    src[6] = dataical;
    src[7] = frac;
    src[8] = (ev + evb) / 2.0;
    src[9] = pdb ? vddana_1p8 : 0.0;
    chk({tag, " vout"}, Vout, ev);
    chk({tag, " voutb"}, Voutb, evb);
    chk({tag, " ical"}, Ical, ei);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s atb%0d", tag, i), atb[i],
          atb_ena[i] ? src[i] : 0.0);
  endtask

  task automatic go(input logic [0:16] t,
                    input logic [0:6] b,
                    input int bad,
                    input string tag);
    @(negedge clkin);
    drive(t, b, bad);
    edge_step();
    check_all(tag);
  endtask

  initial begin
    rst        = 1'b1;
    pdb        = 1'b1;
    atb_ena    = '0;
    dataical   = 0.0;
    vddana_1p8 = 1.8;
    vddana_0p8 = 0.8;
    vssana     = 0.0;
    drive('0, '0, -1);
    #1;
    check_all("reset");
    chk("reset voutb const", Voutb, 0.8);
    @(negedge clkin);
    rst = 1'b0;

    go('1, 7'h7f, -1, "full");
    chk("full vout const", Vout, 0.8);
    chk("full voutb const", Voutb, 0.0);

    go(17'b00100110010010000, 7'b0000001, -1, "c641");
    chk("c641 vout const", Vout, 0.8 * 641.0 / 2303.0);
    chk("c641 voutb const", Voutb,
        0.8 * 1662.0 / 2303.0);

    go(17'h1ffff, 7'h55, 3, "badbin");
    chk("badbin hold", Vout, 0.8 * 641.0 / 2303.0);
    go(17'h00001, 7'h02, 12, "badtherm");

    @(negedge clkin);
    pdb = 1'b0;
    dataical = 1e-6;
    drive(17'h0000f, 7'h11, -1);
    #1;
    check_all("pdb0 comb");
    chk("pdb0 ical const", Ical, 0.0);
    edge_step();
    check_all("pdb0 edge");
    @(negedge clkin);
    pdb = 1'b1;
    edge_step();
    check_all("pdb1 edge");
    chk("pdb1 ical const", Ical, 1e-6);

    atb_ena = 10'b1000000000;
    go('1, 7'h7f, -1, "atb");
    chk("atb0 const", atb[0], 0.8);

    @(negedge clkin);
    vddana_0p8 = 0.9;
    vssana = 0.1;
    atb_ena = '1;
    #1;
    check_all("supply");
    @(negedge clkin);
    vddana_0p8 = 0.8;
    vssana = 0.0;

    @(negedge clkin);
    rst = 1'b1;
    #1;
    exp_code = 0;
    check_all("async rst");
    @(negedge clkin);
    rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      int bad;
      bad = ($urandom_range(0, 4) == 0)
          ? int'($urandom_range(0, 23)) : -1;
      @(negedge clkin);
      pdb = ($urandom_range(0, 9) != 0);
      atb_ena = 10'($urandom);
      dataical = real'($urandom_range(1, 1000)) * 1e-9;
      drive(17'($urandom), 7'($urandom), bad);
      edge_step();
      check_all($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
